// File: rtl/psk_pkg.sv
// Shared types and widths for the PSK phase peak search.
// Holds the FSM state enum, the phase word width and the magnitude width.
package psk_pkg;

   localparam int PCW_W = 12;
   localparam int VAL_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      COMPARE,
      REPORT
   } state_t;

endpackage

// File: rtl/psk_avg_acc.sv
// Strobe counter, accumulator and shift-average for one phase bin.
// Ports: clk, rst_in (sync, active-low), clr_i, en_i, value_i -> last_o, avg_o.
module psk_avg_acc
   import psk_pkg::*;
#(
   parameter int NAVG = 4
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [VAL_W-1:0] value_i,
   output logic             last_o,
   output logic [VAL_W-1:0] avg_o
);

   localparam int LGA = $clog2(NAVG);
   localparam int CW  = (LGA > 0) ? LGA : 1;
   localparam int AW  = VAL_W + LGA;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;

   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (clr_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
         acc_d = acc_q + AW'(value_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   // High on the strobe that completes the bin's average.
   assign last_o = en_i && (cnt_q == CW'(NAVG - 1));
   assign avg_o  = VAL_W'(acc_q >> LGA);

endmodule

// File: rtl/psk_peak_search.sv
// Sweeps NBINS phase bins, averages NAVG strobes each, reports the best bin.
// Ports: clk, rst_in, start, value, stb, res_ready -> pcw, busy, res_valid,
// peak_bin, peak_value, lock. Macro PSK_PEAK_THRESH_EN enables lock.
module psk_peak_search
   import psk_pkg::*;
#(
   parameter int         NBINS  = 16,
   parameter int         NAVG   = 4,
   parameter int         NSKIP  = 1,
   parameter logic [7:0] THRESH = 8'd96
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             start,
   input  logic [VAL_W-1:0] value,
   input  logic             stb,
   output logic [PCW_W-1:0] pcw,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [5:0]       peak_bin,
   output logic [VAL_W-1:0] peak_value,
   output logic             lock
);

   localparam int LGB = $clog2(NBINS);
   localparam int SKW = $clog2(NSKIP + 1) + 1;

   state_t           state_q, state_d;
   logic [LGB-1:0]   bin_q, bin_d;
   logic [SKW-1:0]   skip_q, skip_d;
   logic [VAL_W-1:0] best_val_q, best_val_d;
   logic [LGB-1:0]   best_bin_q, best_bin_d;
   logic [PCW_W-1:0] pcw_q, pcw_d;
   logic [5:0]       pk_bin_q, pk_bin_d;
   logic [VAL_W-1:0] pk_val_q, pk_val_d;

   logic             acc_clr;
   logic             acc_en;
   logic             acc_last;
   logic [VAL_W-1:0] avg;

   assign acc_clr = (state_q == IDLE) || (state_q == COMPARE);
   assign acc_en  = (state_q == MEASURE) && stb;

   psk_avg_acc #(
      .NAVG(NAVG)
   ) u_acc (
      .clk    (clk),
      .rst_in (rst_in),
      .clr_i  (acc_clr),
      .en_i   (acc_en),
      .value_i(value),
      .last_o (acc_last),
      .avg_o  (avg)
   );

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      skip_d     = skip_q;
      best_val_d = best_val_q;
      best_bin_d = best_bin_q;
      pk_bin_d   = pk_bin_q;
      pk_val_d   = pk_val_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SETTLE;
               bin_d      = '0;
               skip_d     = '0;
               best_val_d = '0;
               best_bin_d = '0;
            end
         end
         SETTLE: begin
            if (NSKIP == 0) begin
               state_d = MEASURE;
            end else if (stb) begin
               if (skip_q == SKW'(NSKIP - 1)) begin
                  skip_d  = '0;
                  state_d = MEASURE;
               end else begin
                  skip_d = skip_q + 1'b1;
               end
            end
         end
         MEASURE: begin
            if (acc_last) state_d = COMPARE;
         end
         COMPARE: begin
            // Strict compare: an equal later bin never displaces an earlier one.
            if (avg > best_val_q) begin
               best_val_d = avg;
               best_bin_d = bin_q;
            end
            pk_val_d = best_val_d;
            pk_bin_d = 6'(best_bin_d);
            if (bin_q == LGB'(NBINS - 1)) begin
               state_d = REPORT;
            end else begin
               bin_d   = bin_q + 1'b1;
               state_d = SETTLE;
            end
         end
         REPORT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered from bin_d so the NCO word moves on the same edge as bin.
      pcw_d = PCW_W'(bin_d) << (PCW_W - LGB);
   end

   always_ff @(posedge clk) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         skip_q     <= '0;
         best_val_q <= '0;
         best_bin_q <= '0;
         pcw_q      <= '0;
         pk_bin_q   <= '0;
         pk_val_q   <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         skip_q     <= skip_d;
         best_val_q <= best_val_d;
         best_bin_q <= best_bin_d;
         pcw_q      <= pcw_d;
         pk_bin_q   <= pk_bin_d;
         pk_val_q   <= pk_val_d;
      end
   end

`ifdef PSK_PEAK_THRESH_EN
   logic lock_q, lock_d;

   always_comb begin
      lock_d = lock_q;
      if (state_q == COMPARE) lock_d = (best_val_d > THRESH);
   end

   always_ff @(posedge clk) begin
      if (!rst_in) lock_q <= 1'b0;
      else         lock_q <= lock_d;
   end

   assign lock = lock_q;
`else
   // Constant-only reference; no comparator is built.
   logic unused_thresh;
   assign unused_thresh = ^THRESH;
   assign lock          = 1'b0;
`endif

   assign pcw        = pcw_q;
   assign busy       = (state_q == SETTLE) || (state_q == MEASURE) ||
                       (state_q == COMPARE);
   assign res_valid  = (state_q == REPORT);
   assign peak_bin   = pk_bin_q;
   assign peak_value = pk_val_q;

endmodule

// File: tb/tb_psk_peak_search.sv
// Directed self-checking bench for psk_peak_search (NBINS=16, NAVG=4, NSKIP=1).
// Strobes are paced one every two cycles so COMPARE falls in a quiet cycle.
module tb_psk_peak_search;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        start;
   logic [7:0]  value;
   logic        stb;
   logic [11:0] pcw;
   logic        busy;
   logic        res_valid;
   logic        res_ready;
   logic [5:0]  peak_bin;
   logic [7:0]  peak_value;
   logic        lock;

   int total = 0;
   int bad   = 0;

`ifdef PSK_PEAK_THRESH_EN
   localparam logic LK = 1'b1;
`else
   localparam logic LK = 1'b0;
`endif

   always #5 clk = ~clk;

   psk_peak_search #(
      .NBINS (16),
      .NAVG  (4),
      .NSKIP (1),
      .THRESH(8'd96)
   ) dut (
      .clk       (clk),
      .rst_in    (rst_in),
      .start     (start),
      .value     (value),
      .stb       (stb),
      .pcw       (pcw),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .peak_bin  (peak_bin),
      .peak_value(peak_value),
      .lock      (lock)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // k==0 is the settling strobe, k=1..4 are the averaged strobes.
   function automatic logic [7:0] vfun(input int mode, input int b,
                                       input int k);
      if (mode == 0) begin
         if (k == 0) return 8'd255;
         return (b == 5) ? 8'd200 : 8'd50;
      end
      if (mode == 1) return 8'd100;
      if (k == 0) return 8'd7;
      if (b == 3) return (k % 2 == 1) ? 8'd255 : 8'd0;
      return 8'd10;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_bin(input int mode, input int b, input int nstb);
      for (int k = 0; k < nstb; k++) begin
         stb   = 1'b1;
         value = vfun(mode, b, k);
         tick();
         stb   = 1'b0;
         value = 8'd0;
         tick();
      end
   endtask

   task automatic sweep(input int mode);
      for (int b = 0; b < 16; b++) begin
         chk($sformatf("pcw_bin%0d", b), 32'(pcw), 32'(b << 8));
         chk($sformatf("busy_bin%0d", b), 32'(busy), 32'd1);
         feed_bin(mode, b, 5);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_in    = 1'b0;
      start     = 1'b0;
      stb       = 1'b0;
      value     = 8'd0;
      res_ready = 1'b0;
      repeat (3) tick();
      chk("rst_pcw", 32'(pcw), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_bin", 32'(peak_bin), 32'd0);
      chk("rst_val", 32'(peak_value), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
      rst_in = 1'b1;
      tick();

      // Stray strobe in IDLE must not start anything.
      stb   = 1'b1;
      value = 8'd255;
      tick();
      stb   = 1'b0;
      chk("idle_stb_busy", 32'(busy), 32'd0);

      // Sweep A: bin 5 strong, settling strobes loud to expose miscounts.
      pulse_start();
      sweep(0);
      chk("a_valid", 32'(res_valid), 32'd1);
      chk("a_busy", 32'(busy), 32'd0);
      chk("a_bin", 32'(peak_bin), 32'd5);
      chk("a_val", 32'(peak_value), 32'd200);
      chk("a_lock", 32'(lock), 32'(LK));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("a_drop", 32'(res_valid), 32'd0);
      repeat (3) tick();
      chk("a_hold_bin", 32'(peak_bin), 32'd5);
      chk("a_hold_val", 32'(peak_value), 32'd200);

      // Sweep B: start with coincident strobe, flat input -> tie to bin 0.
      start = 1'b1;
      stb   = 1'b1;
      value = 8'd255;
      tick();
      start = 1'b0;
      stb   = 1'b0;
      value = 8'd0;
      tick();
      sweep(1);
      chk("b_bin", 32'(peak_bin), 32'd0);
      chk("b_val", 32'(peak_value), 32'd100);
      chk("b_lock", 32'(lock), 32'(LK));

      // Backpressure: outputs frozen, start and stb ignored.
      for (int c = 0; c < 20; c++) begin
         start = (c == 5);
         stb   = (c == 10);
         value = 8'd255;
         tick();
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_busy", 32'(busy), 32'd0);
         chk("bp_bin", 32'(peak_bin), 32'd0);
         chk("bp_val", 32'(peak_value), 32'd100);
      end
      start     = 1'b0;
      stb       = 1'b0;
      value     = 8'd0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("bp_drop", 32'(res_valid), 32'd0);
      chk("bp_idle", 32'(busy), 32'd0);
      chk("bp_pcw", 32'(pcw), 32'h0f00);

      // Sweep C aborted by reset during bin 7.
      pulse_start();
      for (int b = 0; b < 7; b++) feed_bin(0, b, 5);
      chk("c_pcw7", 32'(pcw), 32'h0700);
      feed_bin(0, 7, 2);
      rst_in = 1'b0;
      tick();
      chk("c_pcw", 32'(pcw), 32'd0);
      chk("c_busy", 32'(busy), 32'd0);
      chk("c_valid", 32'(res_valid), 32'd0);
      chk("c_bin", 32'(peak_bin), 32'd0);
      chk("c_val", 32'(peak_value), 32'd0);
      chk("c_lock", 32'(lock), 32'd0);
      rst_in = 1'b1;
      tick();

      // Sweep D: bin 3 alternates 255/0 -> average 127.
      pulse_start();
      sweep(2);
      chk("d_valid", 32'(res_valid), 32'd1);
      chk("d_bin", 32'(peak_bin), 32'd3);
      chk("d_val", 32'(peak_value), 32'd127);
      chk("d_lock", 32'(lock), 32'(LK));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("d_drop", 32'(res_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psk_peak_search.md
PSK_PEAK_SEARCH -- requirements
Module: psk_peak_search

Interface
REQ-001 SHALL have parameter NBINS, default 16, the number of phase bins per sweep; power of two, 2..64.
REQ-002 SHALL have parameter NAVG, default 4, the correlator strobes averaged per bin; power of two, 1..16.
REQ-003 SHALL have parameter NSKIP, default 1, the strobes discarded after each phase change (settling).
REQ-004 SHALL have parameter THRESH, default 8'd96, the lock threshold on the averaged peak.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a sweep.
REQ-008 SHALL have port value, input, 8 bits: the correlator magnitude from the dispatcher stage.
REQ-009 SHALL have port stb, input, 1 bit: a one-cycle pulse meaning value is valid.
REQ-010 SHALL have port pcw, output, 12 bits: the phase control word driven to the dispatcher NCOs.
REQ-011 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-012 SHALL have port res_valid, output, 1 bit: the result is available.
REQ-013 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port peak_bin, output, 6 bits: the index of the best bin, zero-extended.
REQ-015 SHALL have port peak_value, output, 8 bits: the averaged magnitude of the best bin.
REQ-016 SHALL have port lock, output, 1 bit: peak_value exceeds THRESH (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, MEASURE, COMPARE and REPORT.
REQ-018 IDLE SHALL go to SETTLE on start: clear bin, acc, best_val and best_bin; busy=1.
REQ-019 SETTLE SHALL count NSKIP stb pulses and then go to MEASURE; with NSKIP=0 it SHALL go to MEASURE on the next cycle.
REQ-020 MEASURE SHALL add value to acc on each stb; acc width SHALL be 8+log2(NAVG), so no overflow is possible.
REQ-021 MEASURE SHALL go to COMPARE in the cycle after the NAVG-th stb has been accumulated.
REQ-022 COMPARE SHALL last one cycle: avg = acc >> log2(NAVG); if avg > best_val (strict), update best_val and best_bin; ties SHALL keep the lower bin.
REQ-023 From COMPARE, if bin == NBINS-1 the FSM SHALL go to REPORT; otherwise it SHALL increment bin, clear acc and go to SETTLE.
REQ-024 pcw SHALL equal bin << (12 - log2(NBINS)), registered, and SHALL update in the same cycle bin changes.
REQ-025 In REPORT: res_valid=1; peak_bin, peak_value and lock SHALL be stable; busy=0.
REQ-026 REPORT SHALL go to IDLE in the cycle res_valid && res_ready; res_valid SHALL drop in the next cycle.
REQ-027 Outputs peak_bin, peak_value and lock SHALL hold their last result in IDLE until the next COMPARE updates them.
REQ-028 stb in IDLE, COMPARE or REPORT SHALL be ignored and not counted.
REQ-029 start while busy or in REPORT SHALL be ignored.
REQ-030 start and stb in the same IDLE cycle: stb SHALL be ignored and the sweep SHALL begin.
REQ-031 Latency from start to res_valid SHALL be NBINS*(NSKIP+NAVG) strobes plus NBINS+1 cycles.

Reset
REQ-032 With rst_in=0 at a clock edge: state=IDLE; pcw=0; busy=0; res_valid=0; peak_bin=0; peak_value=0; lock=0; all counters and acc SHALL be 0.
REQ-033 A reset mid-sweep SHALL abort the sweep with no partial result presented.

Configuration
REQ-034 The macro PSK_PEAK_THRESH_EN SHALL control lock.
REQ-035 With PSK_PEAK_THRESH_EN defined, lock SHALL be registered in COMPARE as (best_val > THRESH).
REQ-036 Without PSK_PEAK_THRESH_EN, lock SHALL be constant 0 and THRESH unused; no comparator SHALL be synthesised.

Structure
REQ-037 A shared package psk_pkg SHALL hold the FSM state enum, PCW_W=12 and VAL_W=8.
REQ-038 One sub-module, psk_avg_acc, SHALL contain the strobe counter, the accumulator and the shift-average.

Verification
REQ-039 NBINS=16, NAVG=4, NSKIP=1; bin 5 values=200, all others=50 -> peak_bin=5, peak_value=200, lock=1.
REQ-040 All bins constant 100 -> peak_bin=0 (tie rule); lock=1 with the macro, 0 without.
REQ-041 Bin 3 values alternate 255/0 under NAVG=4 -> avg=127; no overflow; peak_bin=3.
REQ-042 Hold res_ready=0 for 20 cycles -> res_valid and outputs stable; start pulses ignored; res_ready=1 -> IDLE next cycle.
REQ-043 rst_in=0 during bin 7 -> all outputs 0 next cycle; a new start yields a correct full sweep.
REQ-044 Check pcw sequence across the sweep: 0x000, 0x100, ..., 0xF00.
